// File: rtl/pe_cluster_iact_dist.sv
// Registered iact distribution network: ROWS router channels fan out to a ROWS x COLS PE array.
// Optional perf counters (perf_words, perf_stall) exist when PE_CLUSTER_IACT_PERF_CNT_EN is defined.

module pe_cluster_iact_stream #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int W    = 8,
    parameter int CW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [CW-1:0]          col,
    input  logic [ROWS-1:0]        accept,
    input  logic [ROWS*W-1:0]      rt_bits,
    input  logic [ROWS*COLS-1:0]   pe_ready,
    output logic [ROWS*COLS-1:0]   pe_valid,
    output logic [ROWS*COLS*W-1:0] pe_bits,
    output logic [ROWS-1:0]        full,
    output logic [ROWS-1:0]        complete
);
    localparam int P = ROWS * COLS;

    logic [ROWS-1:0][W-1:0] payload;
    logic [ROWS-1:0][P-1:0] taken;
    logic [ROWS-1:0][P-1:0] dmask;
    logic [P-1:0]           hs;

    // Each PE is owned by at most one router in every mode, so OR-merging is a mux.
    always_comb begin
        dmask = '0;
        for (int k = 0; k < ROWS; k++) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    case (mode)
                        2'd1:    dmask[k][i*COLS+j] = (((i + j) % ROWS) == k);
                        2'd2:    dmask[k][i*COLS+j] = (i == k) && (j == int'(col));
                        default: dmask[k][i*COLS+j] = (i == k);
                    endcase
                end
            end
        end
    end

    always_comb begin
        pe_valid = '0;
        pe_bits  = '0;
        for (int p = 0; p < P; p++) begin
            for (int k = 0; k < ROWS; k++) begin
                if (dmask[k][p]) begin
                    pe_valid[p]        = pe_valid[p] | (full[k] & ~taken[k][p]);
                    pe_bits[p*W +: W]  = pe_bits[p*W +: W] | payload[k];
                end
            end
        end
    end

    assign hs = pe_valid & pe_ready;

    always_comb begin
        complete = '0;
        for (int k = 0; k < ROWS; k++) begin
            complete[k] = full[k] & (&(~dmask[k] | taken[k] | hs));
        end
    end

    // Loading is only possible when empty or completing, so taken is always clear for a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            taken   <= '0;
            payload <= '0;
        end else begin
            for (int k = 0; k < ROWS; k++) begin
                if (complete[k]) begin
                    full[k]  <= 1'b0;
                    taken[k] <= '0;
                end else begin
                    taken[k] <= taken[k] | (hs & dmask[k]);
                end
                if (accept[k]) begin
                    full[k]    <= 1'b1;
                    payload[k] <= rt_bits[k*W +: W];
                end
            end
        end
    end
endmodule

module pe_cluster_iact_dist #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        cfg_mode,
    input  logic [(COLS>1?$clog2(COLS):1)-1:0] cfg_col,
    input  logic                              cfg_load,
    output logic                              cfg_busy,
    input  logic [ROWS-1:0]                   rt_addr_valid,
    output logic [ROWS-1:0]                   rt_addr_ready,
    input  logic [ROWS*ADDR_W-1:0]            rt_addr_bits,
    input  logic [ROWS-1:0]                   rt_data_valid,
    output logic [ROWS-1:0]                   rt_data_ready,
    input  logic [ROWS*DATA_W-1:0]            rt_data_bits,
    output logic [ROWS*COLS-1:0]              pe_addr_valid,
    input  logic [ROWS*COLS-1:0]              pe_addr_ready,
    output logic [ROWS*COLS*ADDR_W-1:0]       pe_addr_bits,
    output logic [ROWS*COLS-1:0]              pe_data_valid,
    input  logic [ROWS*COLS-1:0]              pe_data_ready,
    output logic [ROWS*COLS*DATA_W-1:0]       pe_data_bits
`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
    ,
    output logic [ROWS*32-1:0]                perf_words,
    output logic [31:0]                       perf_stall
`endif
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [1:0]      act_mode;
    logic [CW-1:0]   act_col;
    logic            pending;
    logic [ROWS-1:0] full_a, full_d, done_a, done_d;
    logic            all_empty;

    assign all_empty     = ~|{full_a, full_d};
    assign cfg_busy      = pending | ~all_empty;
    assign rt_addr_ready = {ROWS{~pending}} & (~full_a | done_a);
    assign rt_data_ready = {ROWS{~pending}} & (~full_d | done_d);

    // Commit takes priority, so a cfg_load arriving while pending is absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            act_mode <= 2'd0;
            act_col  <= '0;
        end else if (pending && all_empty) begin
            pending  <= 1'b0;
            act_mode <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
            act_col  <= cfg_col;
        end else if (cfg_load) begin
            pending <= 1'b1;
        end
    end

    pe_cluster_iact_stream #(.ROWS(ROWS), .COLS(COLS), .W(ADDR_W), .CW(CW)) u_addr (
        .clk(clk), .rst_n(rst_n), .mode(act_mode), .col(act_col),
        .accept(rt_addr_valid & rt_addr_ready), .rt_bits(rt_addr_bits),
        .pe_ready(pe_addr_ready), .pe_valid(pe_addr_valid), .pe_bits(pe_addr_bits),
        .full(full_a), .complete(done_a)
    );

    pe_cluster_iact_stream #(.ROWS(ROWS), .COLS(COLS), .W(DATA_W), .CW(CW)) u_data (
        .clk(clk), .rst_n(rst_n), .mode(act_mode), .col(act_col),
        .accept(rt_data_valid & rt_data_ready), .rt_bits(rt_data_bits),
        .pe_ready(pe_data_ready), .pe_valid(pe_data_valid), .pe_bits(pe_data_bits),
        .full(full_d), .complete(done_d)
    );

`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words <= '0;
            perf_stall <= '0;
        end else if (cfg_load) begin
            perf_words <= '0;
            perf_stall <= '0;
        end else begin
            for (int k = 0; k < ROWS; k++) begin
                if (done_d[k]) perf_words[k*32 +: 32] <= perf_words[k*32 +: 32] + 32'd1;
            end
            if (|(pe_data_valid & ~pe_data_ready)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pe_cluster_iact_dist.sv
// Directed self-checking bench for pe_cluster_iact_dist (3x3, default widths).
// Covers the perf counters as well when PE_CLUSTER_IACT_PERF_CNT_EN is defined.

module tb_pe_cluster_iact_dist;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int AW   = 8;
    localparam int DW   = 13;
    localparam int P    = ROWS * COLS;

    logic               clk;
    logic               rst_n;
    logic [1:0]         cfg_mode;
    logic [1:0]         cfg_col;
    logic               cfg_load;
    logic               cfg_busy;
    logic [ROWS-1:0]    rt_addr_valid, rt_addr_ready;
    logic [ROWS*AW-1:0] rt_addr_bits;
    logic [ROWS-1:0]    rt_data_valid, rt_data_ready;
    logic [ROWS*DW-1:0] rt_data_bits;
    logic [P-1:0]       pe_addr_valid, pe_addr_ready;
    logic [P*AW-1:0]    pe_addr_bits;
    logic [P-1:0]       pe_data_valid, pe_data_ready;
    logic [P*DW-1:0]    pe_data_bits;
`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
    logic [ROWS*32-1:0] perf_words;
    logic [31:0]        perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    pe_cluster_iact_dist #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_mode(cfg_mode), .cfg_col(cfg_col), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
        .rt_addr_valid(rt_addr_valid), .rt_addr_ready(rt_addr_ready), .rt_addr_bits(rt_addr_bits),
        .rt_data_valid(rt_data_valid), .rt_data_ready(rt_data_ready), .rt_data_bits(rt_data_bits),
        .pe_addr_valid(pe_addr_valid), .pe_addr_ready(pe_addr_ready), .pe_addr_bits(pe_addr_bits),
        .pe_data_valid(pe_data_valid), .pe_data_ready(pe_data_ready), .pe_data_bits(pe_data_bits)
`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
        , .perf_words(perf_words), .perf_stall(perf_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dbits(input int p);
        return pe_data_bits[p*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] abits(input int p);
        return pe_addr_bits[p*AW +: AW];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_mode = 2'd0; cfg_col = 2'd0; cfg_load = 1'b0;
        rt_addr_valid = '0; rt_addr_bits = '0;
        rt_data_valid = '0; rt_data_bits = '0;
        pe_addr_ready = '0; pe_data_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pe_data_valid !== 9'h000) begin errors++; $display("FAIL reset_in_pe_data_valid got %h want 000", pe_data_valid); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (pe_addr_valid !== 9'h000) begin errors++; $display("FAIL reset_pe_addr_valid got %h want 000", pe_addr_valid); end
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy got %b want 0", cfg_busy); end
        checks++;
        if (rt_data_ready !== 3'b111) begin errors++; $display("FAIL reset_rt_data_ready got %b want 111", rt_data_ready); end
        checks++;
        if (rt_addr_ready !== 3'b111) begin errors++; $display("FAIL reset_rt_addr_ready got %b want 111", rt_addr_ready); end
        checks++;
        if (pe_data_bits !== '0) begin errors++; $display("FAIL reset_pe_data_bits got %h want 0", pe_data_bits); end
    endtask

    task automatic test_bcast();
        logic [DW-1:0] w;
        pe_data_ready = '1; pe_addr_ready = '1;
        tick();
        rt_data_valid = 3'b010;
        rt_data_bits = '0;
        rt_data_bits[1*DW +: DW] = 13'h0A5;
        #1;
        checks++;
        if (rt_data_ready[1] !== 1'b1) begin errors++; $display("FAIL bcast_ready_c0 got %b want 1", rt_data_ready[1]); end
        checks++;
        if (pe_data_valid !== 9'h000) begin errors++; $display("FAIL bcast_no_comb_path got %h want 000", pe_data_valid); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c < 3) rt_data_bits[1*DW +: DW] = 13'h0A5 + 13'(c);
            else rt_data_valid = '0;
            #1;
            w = 13'h0A5 + 13'(c - 1);
            checks++;
            if (pe_data_valid !== 9'h038) begin errors++; $display("FAIL bcast_valid_c%0d got %h want 038", c, pe_data_valid); end
            checks++;
            if (dbits(3) !== w || dbits(4) !== w || dbits(5) !== w)
                begin errors++; $display("FAIL bcast_bits_c%0d got %h %h %h want %h", c, dbits(3), dbits(4), dbits(5), w); end
            checks++;
            if (rt_data_ready[1] !== 1'b1) begin errors++; $display("FAIL bcast_ready_c%0d got %b want 1", c, rt_data_ready[1]); end
        end
        tick();
        #1;
        checks++;
        if (pe_data_valid !== 9'h000) begin errors++; $display("FAIL bcast_drain got %h want 000", pe_data_valid); end
    endtask

    task automatic test_stall();
        pe_data_ready = 9'h1FB;
        tick();
        rt_data_valid = 3'b001;
        rt_data_bits = '0;
        rt_data_bits[0 +: DW] = 13'h123;
        tick();
        rt_data_valid = '0;
        #1;
        checks++;
        if (pe_data_valid !== 9'h007) begin errors++; $display("FAIL stall_valid_c1 got %h want 007", pe_data_valid); end
        checks++;
        if (rt_data_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready_c1 got %b want 0", rt_data_ready[0]); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            #1;
            checks++;
            if (pe_data_valid !== 9'h004) begin errors++; $display("FAIL stall_valid_c%0d got %h want 004", c, pe_data_valid); end
            checks++;
            if (rt_data_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready_c%0d got %b want 0", c, rt_data_ready[0]); end
            checks++;
            if (dbits(2) !== 13'h123) begin errors++; $display("FAIL stall_hold_c%0d got %h want 123", c, dbits(2)); end
        end
        tick();
        pe_data_ready = '1;
        #1;
        checks++;
        if (pe_data_valid !== 9'h004) begin errors++; $display("FAIL stall_valid_c5 got %h want 004", pe_data_valid); end
        checks++;
        if (rt_data_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_ready_c5 got %b want 1", rt_data_ready[0]); end
        tick();
        #1;
        checks++;
        if (pe_data_valid !== 9'h000) begin errors++; $display("FAIL stall_drain got %h want 000", pe_data_valid); end
    endtask

    task automatic test_diag();
        tick();
        cfg_mode = 2'd1; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        #1;
        checks++;
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL diag_busy_pending got %b want 1", cfg_busy); end
        checks++;
        if (rt_addr_ready !== 3'b000) begin errors++; $display("FAIL diag_ready_pending got %b want 000", rt_addr_ready); end
        tick();
        #1;
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL diag_busy_done got %b want 0", cfg_busy); end
        checks++;
        if (rt_addr_ready !== 3'b111) begin errors++; $display("FAIL diag_ready_done got %b want 111", rt_addr_ready); end
        rt_addr_valid = 3'b001;
        rt_addr_bits = '0;
        rt_addr_bits[0 +: AW] = 8'h11;
        tick();
        rt_addr_valid = '0;
        #1;
        checks++;
        if (pe_addr_valid !== 9'h0A1) begin errors++; $display("FAIL diag_valid got %h want 0a1", pe_addr_valid); end
        checks++;
        if (abits(0) !== 8'h11 || abits(5) !== 8'h11 || abits(7) !== 8'h11)
            begin errors++; $display("FAIL diag_bits got %h %h %h want 11", abits(0), abits(5), abits(7)); end
        checks++;
        if (pe_data_valid !== 9'h000) begin errors++; $display("FAIL diag_data_quiet got %h want 000", pe_data_valid); end
        tick();
        #1;
        checks++;
        if (pe_addr_valid !== 9'h000) begin errors++; $display("FAIL diag_drain got %h want 000", pe_addr_valid); end
    endtask

    task automatic test_unicast();
        pe_data_ready = '0;
        tick();
        rt_data_valid = 3'b100;
        rt_data_bits = '0;
        rt_data_bits[2*DW +: DW] = 13'h155;
        tick();
        rt_data_valid = '0;
        cfg_mode = 2'd2; cfg_col = 2'd2; cfg_load = 1'b1;
        #1;
        checks++;
        if (pe_data_valid !== 9'h054) begin errors++; $display("FAIL uni_diag_valid got %h want 054", pe_data_valid); end
        tick();
        cfg_load = 1'b0;
        #1;
        checks++;
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL uni_busy_c2 got %b want 1", cfg_busy); end
        checks++;
        if (rt_data_ready !== 3'b000 || rt_addr_ready !== 3'b000)
            begin errors++; $display("FAIL uni_ready_c2 got %b %b want 000 000", rt_data_ready, rt_addr_ready); end
        tick();
        pe_data_ready = '1;
        #1;
        checks++;
        if (pe_data_valid !== 9'h054) begin errors++; $display("FAIL uni_valid_c3 got %h want 054", pe_data_valid); end
        checks++;
        if (rt_data_ready !== 3'b000) begin errors++; $display("FAIL uni_ready_c3 got %b want 000", rt_data_ready); end
        tick();
        #1;
        checks++;
        if (pe_data_valid !== 9'h000 || cfg_busy !== 1'b1 || rt_data_ready !== 3'b000)
            begin errors++; $display("FAIL uni_drained_c4 got v=%h busy=%b rdy=%b want 000 1 000", pe_data_valid, cfg_busy, rt_data_ready); end
        tick();
        #1;
        checks++;
        if (cfg_busy !== 1'b0 || rt_data_ready !== 3'b111)
            begin errors++; $display("FAIL uni_ready_c5 got busy=%b rdy=%b want 0 111", cfg_busy, rt_data_ready); end
        rt_data_valid = 3'b011;
        rt_data_bits = '0;
        rt_data_bits[0 +: DW] = 13'h011;
        rt_data_bits[1*DW +: DW] = 13'h022;
        tick();
        rt_data_valid = '0;
        #1;
        checks++;
        if (pe_data_valid !== 9'h024) begin errors++; $display("FAIL uni_valid got %h want 024", pe_data_valid); end
        checks++;
        if (dbits(2) !== 13'h011 || dbits(5) !== 13'h022)
            begin errors++; $display("FAIL uni_bits got %h %h want 011 022", dbits(2), dbits(5)); end
        checks++;
        if (dbits(0) !== 13'h000) begin errors++; $display("FAIL uni_untargeted_bits got %h want 000", dbits(0)); end
        tick();
    endtask

    task automatic test_reset_mid();
        pe_data_ready = '0;
        tick();
        rt_data_valid = 3'b001;
        rt_data_bits = '0;
        rt_data_bits[0 +: DW] = 13'h0F0;
        tick();
        rt_data_valid = '0;
        #1;
        checks++;
        if (pe_data_valid !== 9'h004) begin errors++; $display("FAIL rstmid_before got %h want 004", pe_data_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pe_data_valid !== 9'h000 || cfg_busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_async got v=%h busy=%b want 000 0", pe_data_valid, cfg_busy); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rt_data_ready !== 3'b111 || rt_addr_ready !== 3'b111)
            begin errors++; $display("FAIL rstmid_ready got %b %b want 111 111", rt_data_ready, rt_addr_ready); end
        pe_data_ready = '1;
        rt_data_valid = 3'b001;
        rt_data_bits[0 +: DW] = 13'h0F1;
        tick();
        rt_data_valid = '0;
        #1;
        checks++;
        if (pe_data_valid !== 9'h007) begin errors++; $display("FAIL rstmid_bcast_mode got %h want 007", pe_data_valid); end
        checks++;
        if (dbits(1) !== 13'h0F1) begin errors++; $display("FAIL rstmid_bits got %h want 0f1", dbits(1)); end
        tick();
    endtask

`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
    task automatic test_perf();
        cfg_mode = 2'd0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (perf_words !== '0 || perf_stall !== 32'd0)
            begin errors++; $display("FAIL perf_clear got %h %h want 0 0", perf_words, perf_stall); end
        pe_data_ready = 9'h1BF;
        rt_data_valid = 3'b100;
        rt_data_bits = '0;
        rt_data_bits[2*DW +: DW] = 13'h001;
        tick();
        rt_data_valid = '0;
        tick();
        tick();
        tick();
        pe_data_ready = '1;
        rt_data_valid = 3'b100;
        for (int w = 2; w <= 5; w++) begin
            rt_data_bits[2*DW +: DW] = 13'(w);
            tick();
        end
        rt_data_valid = '0;
        tick();
        tick();
        #1;
        checks++;
        if (perf_words[2*32 +: 32] !== 32'd5) begin errors++; $display("FAIL perf_words2 got %0d want 5", perf_words[2*32 +: 32]); end
        checks++;
        if (perf_words[0 +: 32] !== 32'd0) begin errors++; $display("FAIL perf_words0 got %0d want 0", perf_words[0 +: 32]); end
        checks++;
        if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_bcast();
        test_stall();
        test_diag();
        test_unicast();
        test_reset_mid();
`ifdef PE_CLUSTER_IACT_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
